// File: rtl/cache_sim_assoc.sv
// -----------------------------------------------------------------------------
// cache_sim_assoc
//   Set-associative cache tag/LRU simulator for address traces. Each accepted
//   request is looked up, the hit/miss/evict outcome is reported with a
//   one-cycle response pulse, the set's LRU state is updated and the
//   statistics counters are advanced (saturating).
//
//   Timing: accept edge -> LOOKUP -> UPDATE -> IDLE. The set is read into
//   registers at the accept edge (block-RAM style), the outcome is resolved
//   during LOOKUP and registered onto the response outputs for UPDATE; the
//   cache arrays and counters are written at the edge that leaves UPDATE.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   trace_valid  in   trace_addr holds a request
//   trace_addr   in   byte address to look up [ADDR_W]
//   trace_ready  out  block can accept a request (IDLE only)
//   clear_stats  in   synchronous clear of the statistics counters
//   resp_valid   out  one-cycle pulse when a lookup completes
//   resp_hit     out  1 = the completed lookup hit
//   resp_evict   out  1 = the completed lookup replaced a valid line
//   hit_count    out  total hits     [CNT_W], saturating
//   miss_count   out  total misses   [CNT_W], saturating
//   evict_count  out  total evictions[CNT_W], saturating
// -----------------------------------------------------------------------------
module cache_sim_assoc #(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 2,
    parameter int WAYS     = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trace_valid,
    input  logic [ADDR_W-1:0] trace_addr,
    output logic              trace_ready,
    input  logic              clear_stats,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_evict,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  evict_count
);

    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    // A direct-mapped cache keeps a 1-bit age field that is always 0.
    localparam int AGE_W = WAY_W;

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE
    } state_t;

    state_t state;

    // Cache arrays
    logic             valid_mem [SETS][WAYS];
    logic [AGE_W-1:0] age_mem   [SETS][WAYS];
    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];

    // Request captured at the accept edge and the set read alongside it
    logic [INDEX_W-1:0] cap_index;
    logic [TAG_W-1:0]   cap_tag;
    logic               rd_valid [WAYS];
    logic [AGE_W-1:0]   rd_age   [WAYS];
    logic [TAG_W-1:0]   rd_tag   [WAYS];

    // Outcome registered at the end of LOOKUP, committed at the end of UPDATE
    logic [WAY_W-1:0] upd_way;
    logic [AGE_W-1:0] upd_age [WAYS];

    // Combinational lookup results (meaningful during LOOKUP)
    logic             hit;
    logic             found_inv;
    logic             evict;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] acc_way;
    logic [AGE_W-1:0] hit_age;
    logic [AGE_W-1:0] lru_age;
    logic [AGE_W-1:0] old_age;
    logic [AGE_W-1:0] new_age [WAYS];

    logic accept;
    logic unused_offset;

    assign accept = trace_valid && trace_ready;

    // The line offset does not take part in the lookup.
    assign unused_offset = ^trace_addr[OFFSET_W-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Lookup: hit detection, victim choice and the set's next ages
    // -------------------------------------------------------------------------
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        hit_age   = '0;
        found_inv = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        lru_age   = rd_age[0];

        for (int unsigned i = 0; i < WAYS; i++) begin
            if (rd_valid[i] && (rd_tag[i] == cap_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
                hit_age = rd_age[i];
            end
            if (!rd_valid[i] && !found_inv) begin
                found_inv = 1'b1;
                inv_way   = WAY_W'(i);
            end
            // Strictly greater keeps the lowest index on an age tie.
            if (rd_age[i] > lru_age) begin
                lru_age = rd_age[i];
                lru_way = WAY_W'(i);
            end
        end

        evict = !hit && !found_inv;

        if (hit) begin
            acc_way = hit_way;
            old_age = hit_age;
        end else if (found_inv) begin
            acc_way = inv_way;
            old_age = AGE_MAX;
        end else begin
            acc_way = lru_way;
            old_age = lru_age;
        end

        // Valid ways younger than the accessed one age by one; the accessed
        // way becomes the most recent.
        for (int unsigned j = 0; j < WAYS; j++) begin
            new_age[j] = rd_age[j];
            if (WAY_W'(j) == acc_way) begin
                new_age[j] = '0;
            end else if (rd_valid[j] && (rd_age[j] < old_age)) begin
                new_age[j] = rd_age[j] + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered handshake/response outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            trace_ready <= 1'b1;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_evict  <= 1'b0;
            upd_way     <= '0;
            for (int unsigned i = 0; i < WAYS; i++) begin
                upd_age[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= LOOKUP;
                        trace_ready <= 1'b0;
                    end
                end
                LOOKUP: begin
                    state      <= UPDATE;
                    resp_valid <= 1'b1;
                    resp_hit   <= hit;
                    resp_evict <= evict;
                    upd_way    <= acc_way;
                    for (int unsigned i = 0; i < WAYS; i++) begin
                        upd_age[i] <= new_age[i];
                    end
                end
                UPDATE: begin
                    state       <= IDLE;
                    resp_valid  <= 1'b0;
                    trace_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    trace_ready <= 1'b1;
                    resp_valid  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Request capture, registered set read and tag write (no reset needed)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_index <= trace_addr[OFFSET_W +: INDEX_W];
            cap_tag   <= trace_addr[ADDR_W-1 -: TAG_W];
            for (int unsigned i = 0; i < WAYS; i++) begin
                rd_valid[i] <= valid_mem[trace_addr[OFFSET_W +: INDEX_W]][i];
                rd_age[i]   <= age_mem[trace_addr[OFFSET_W +: INDEX_W]][i];
                rd_tag[i]   <= tag_mem[trace_addr[OFFSET_W +: INDEX_W]][i];
            end
        end
        if (state == UPDATE) begin
            tag_mem[cap_index][upd_way] <= cap_tag;
        end
    end

    // -------------------------------------------------------------------------
    // Valid bits and ages
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                    age_mem[s][w]   <= '0;
                end
            end
        end else if (state == UPDATE) begin
            valid_mem[cap_index][upd_way] <= 1'b1;
            for (int unsigned w = 0; w < WAYS; w++) begin
                age_mem[cap_index][w] <= upd_age[w];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Statistics counters; a clear wins over a same-edge increment
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count   <= '0;
            miss_count  <= '0;
            evict_count <= '0;
        end else if (clear_stats) begin
            hit_count   <= '0;
            miss_count  <= '0;
            evict_count <= '0;
        end else if (state == UPDATE) begin
            if (resp_hit) begin
                hit_count <= sat_inc(hit_count);
            end else begin
                miss_count <= sat_inc(miss_count);
            end
            if (resp_evict) begin
                evict_count <= sat_inc(evict_count);
            end
        end
    end

endmodule
